// File: rtl/fifo_wr_frame_packer.sv
// fifo_wr_frame_packer
//   Write-domain producer for an async FIFO write port. Accepts one result
//   word per request and serialises it into 1 or 2 bytes, low byte first,
//   pushing each byte only when the FIFO reports not-full. Requests that
//   arrive while a frame is in flight are dropped and counted (saturating).
//
//   Optional feature macro: PACKER_CKSUM_EN
//     When defined, each frame is followed by one checksum byte equal to the
//     XOR of all data bytes in the frame (2- or 3-byte frames). When not
//     defined, frames are 1 or 2 bytes and no checksum logic exists.
//
//   Outputs w_inc / w_data decode only the state register and the latched
//   request, so there is no combinational path from in_* to the FIFO port.
//   wfull only gates state advance; a presented byte is never retracted.
module fifo_wr_frame_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    w_clk,
    input  logic                    w_rst_n,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_two,
    output logic                    in_ready,
    input  logic                    wfull,
    output logic                    w_inc,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);

    // Frame sequencer states; the checksum state only exists with the feature.
`ifdef PACKER_CKSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        SEND_CK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;
`endif

    // Latched request: the word to serialise and whether the high byte goes out.
    typedef struct packed {
        logic                    two;
        logic [2*DATA_WIDTH-1:0] word;
    } req_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state_q;
    state_t                  state_d;
    req_t                    req_q;
    logic                    accept;
    logic                    push;
    logic [DATA_WIDTH-1:0]   lo_byte;
    logic [DATA_WIDTH-1:0]   hi_byte;

    assign lo_byte = req_q.word[DATA_WIDTH-1:0];
    assign hi_byte = req_q.word[2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef PACKER_CKSUM_EN
    logic [DATA_WIDTH-1:0]   ck_byte;
    // A 1-byte frame's checksum is just its low byte (XOR over one byte).
    assign ck_byte = req_q.two ? (lo_byte ^ hi_byte) : lo_byte;
`endif

    // Handshake decode: ready only while idle; a push is w_inc seen with room.
    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_ready & in_valid;
    assign push     = w_inc & ~wfull;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request on accept only; dropped requests never touch it.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.word <= in_data;
            req_q.two  <= in_two;
        end
    end

    // Count valid requests that arrive while busy, sticking at all-ones.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    // Next-state and FIFO-port decode; each send state holds until its push.
    always_comb begin
        state_d = state_q;
        w_inc   = 1'b0;
        w_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) state_d = SEND_LO;
            end
            SEND_LO: begin
                w_inc  = 1'b1;
                w_data = lo_byte;
                if (push) begin
`ifdef PACKER_CKSUM_EN
                    state_d = req_q.two ? SEND_HI : SEND_CK;
`else
                    state_d = req_q.two ? SEND_HI : IDLE;
`endif
                end
            end
            SEND_HI: begin
                w_inc  = 1'b1;
                w_data = hi_byte;
                if (push) begin
`ifdef PACKER_CKSUM_EN
                    state_d = SEND_CK;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PACKER_CKSUM_EN
            SEND_CK: begin
                w_inc  = 1'b1;
                w_data = ck_byte;
                if (push) state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_frame_packer.sv
// tb_fifo_wr_frame_packer
//   Directed scenarios plus a randomized run. A negedge monitor keeps a
//   frame-level reference: on each accepted request it queues the bytes the
//   frame should produce; every push the DUT makes is collected separately.
module tb_fifo_wr_frame_packer;

    localparam int DW = 8;
    localparam int CW = 8;
`ifdef PACKER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          w_clk    = 1'b0;
    logic          w_rst_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic [2*DW-1:0] in_data = '0;
    logic          in_two   = 1'b0;
    logic          in_ready;
    logic          wfull    = 1'b0;
    logic          w_inc;
    logic [DW-1:0] w_data;
    logic          busy;
    logic [CW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int frm_left = 0;
    int drop_m   = 0;
    int rdy_bad  = 0;

    fifo_wr_frame_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_two(in_two), .in_ready(in_ready), .wfull(wfull), .w_inc(w_inc),
        .w_data(w_data), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 w_clk = ~w_clk;

    // Reference: inputs change just after posedge, so at negedge both the
    // inputs and outputs are the values the next posedge will act on.
    always @(negedge w_clk) begin
        if (!w_rst_n) begin
            repeat (frm_left) void'(exp_q.pop_back());
            frm_left = 0;
            drop_m   = 0;
        end else begin
            automatic bit idle = (frm_left == 0);
            automatic logic [7:0] lo = in_data[7:0];
            automatic logic [7:0] hi = in_data[15:8];
            if (in_ready !== idle || busy !== !idle || w_inc !== !idle) rdy_bad++;
            if (!idle && in_valid && drop_m < 255) drop_m++;
            if (!idle && !wfull) begin
                got_q.push_back(w_data);
                frm_left--;
            end else if (idle && in_valid) begin
                exp_q.push_back(lo);
                if (in_two) exp_q.push_back(hi);
                if (CK != 0) exp_q.push_back(in_two ? (lo ^ hi) : lo);
                frm_left = 1 + int'(in_two) + CK;
            end
        end
    end

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL wait_idle: in_ready=%0b after %0d cycles, need 1", in_ready, k);
        end
    endtask

    task automatic test_reset;
        w_rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || w_inc !== 1'b0 || w_data !== 8'h00 || drop_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b busy=%0b inc=%0b data=%h drop=%h, need 1 0 0 00 00",
                     in_ready, busy, w_inc, w_data, drop_cnt);
        end
        w_rst_n = 1'b1;
        tick();
    endtask

    // One-byte frame: first byte one cycle after accept, ready returns after the last push.
    task automatic test_single;
        in_valid = 1'b1; in_data = 16'h00A5; in_two = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (w_inc !== 1'b1 || w_data !== 8'hA5 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_byte0: inc=%0b data=%h rdy=%0b, need 1 a5 0", w_inc, w_data, in_ready);
        end
        tick();
`ifdef PACKER_CKSUM_EN
        n_cmp++;
        if (w_inc !== 1'b1 || w_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_cksum: inc=%0b data=%h, need 1 a5", w_inc, w_data);
        end
        tick();
`endif
        n_cmp++;
        if (w_inc !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: inc=%0b rdy=%0b, need 0 1", w_inc, in_ready);
        end
    endtask

    // Two-byte frame at full rate; ready low for exactly the frame length.
    task automatic test_two;
        logic [7:0] want [3];
        int low_cycles = 0;
        want[0] = 8'h34; want[1] = 8'h12; want[2] = 8'h26;
        in_valid = 1'b1; in_data = 16'h1234; in_two = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 2 + CK; b++) begin
            if (!in_ready) low_cycles++;
            n_cmp++;
            if (w_inc !== 1'b1 || w_data !== want[b]) begin
                n_err++;
                $display("FAIL two_byte%0d: inc=%0b data=%h, need 1 %h", b, w_inc, w_data, want[b]);
            end
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b1 || low_cycles != 2 + CK) begin
            n_err++;
            $display("FAIL two_ready: rdy=%0b low_cycles=%0d, need 1 %0d", in_ready, low_cycles, 2 + CK);
        end
    endtask

    // wfull held after the first push: high byte stays presented, then goes exactly once.
    task automatic test_stall;
        exp_q.delete(); got_q.delete();
        in_valid = 1'b1; in_data = 16'h1234; in_two = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        wfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (w_inc !== 1'b1 || w_data !== 8'h12) begin
                n_err++;
                $display("FAIL stall_hold%0d: inc=%0b data=%h, need 1 12", k, w_inc, w_data);
            end
            tick();
        end
        wfull = 1'b0;
        wait_idle();
        n_cmp++;
        if (got_q.size() != 2 + CK || got_q != exp_q || got_q[1] !== 8'h12) begin
            n_err++;
            $display("FAIL stall_bytes: got %0d bytes %p, need %0d bytes %p", got_q.size(), got_q, 2 + CK, exp_q);
        end
    endtask

    // in_valid held through a frame is counted, not accepted; then saturate the counter.
    task automatic test_drop;
        exp_q.delete(); got_q.delete();
        in_valid = 1'b1; in_data = 16'h1234; in_two = 1'b1;
        tick();
        in_data = 16'hBEEF; in_two = 1'b0;
        repeat (2 + CK) tick();
        in_valid = 1'b0;
        n_cmp++;
        if (drop_cnt !== 8'(2 + CK) || int'(drop_cnt) != drop_m) begin
            n_err++;
            $display("FAIL drop_count: drop=%0d, need %0d", drop_cnt, 2 + CK);
        end
        tick();
        n_cmp++;
        if (got_q.size() != 2 + CK || got_q != exp_q || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL drop_frame: got %p rdy=%0b, need %p rdy=1", got_q, in_ready, exp_q);
        end
        wfull = 1'b1; in_valid = 1'b1;
        tick();
        repeat (300) tick();
        in_valid = 1'b0;
        n_cmp++;
        if (drop_cnt !== 8'hFF) begin
            n_err++;
            $display("FAIL drop_saturate: drop=%h, need ff", drop_cnt);
        end
        wfull = 1'b0;
        wait_idle();
    endtask

    // Reset between the bytes of a frame: outputs clear at once, high byte never pushed.
    task automatic test_reset_mid;
        exp_q.delete(); got_q.delete();
        in_valid = 1'b1; in_data = 16'h1234; in_two = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        w_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_inc !== 1'b0 || w_data !== 8'h00 || in_ready !== 1'b1 || busy !== 1'b0 || drop_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_async: inc=%0b data=%h rdy=%0b busy=%0b drop=%h, need 0 00 1 0 00",
                     w_inc, w_data, in_ready, busy, drop_cnt);
        end
        tick();
        w_rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (in_ready !== 1'b1 || drop_cnt !== 8'h00 || w_inc !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_after: rdy=%0b drop=%h inc=%0b, need 1 00 0", in_ready, drop_cnt, w_inc);
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'h34 || got_q != exp_q) begin
            n_err++;
            $display("FAIL rst_mid_bytes: got %p, need '{34}", got_q);
        end
    endtask

`ifdef PACKER_CKSUM_EN
    // Checksum byte trails the data bytes of each frame.
    task automatic test_cksum;
        exp_q.delete(); got_q.delete();
        in_valid = 1'b1; in_data = 16'h1234; in_two = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_idle();
        in_valid = 1'b1; in_data = 16'h00A5; in_two = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_idle();
        n_cmp++;
        if (got_q.size() != 5 || got_q[0] !== 8'h34 || got_q[1] !== 8'h12 || got_q[2] !== 8'h26 ||
            got_q[3] !== 8'hA5 || got_q[4] !== 8'hA5) begin
            n_err++;
            $display("FAIL cksum_bytes: got %p, need '{34,12,26,a5,a5}", got_q);
        end
    endtask
`endif

    // Random requests and random backpressure, checked against the frame model.
    task automatic test_random;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 16'($urandom);
            in_two   = 1'($urandom);
            wfull    = ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0; wfull = 1'b0;
        wait_idle();
        tick();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d bytes, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_byte%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (int'(drop_cnt) != drop_m) begin
            n_err++;
            $display("FAIL rand_drop: drop=%0d, need %0d", drop_cnt, drop_m);
        end
        n_cmp++;
        if (rdy_bad != 0) begin
            n_err++;
            $display("FAIL handshake: %0d cycles with in_ready/busy/w_inc off the model", rdy_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_stall();
        test_drop();
        test_reset_mid();
`ifdef PACKER_CKSUM_EN
        test_cksum();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
